// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU select codes, sequencer states and widths
package alu_pkg;
  localparam int SEL_W = 3;
  localparam int DATA_W = 8;
  typedef enum logic [SEL_W-1:0] {
    ADD2C = 3'b000,
    SUB2C = 3'b001,
    ADD1C = 3'b010,
    SUB1C = 3'b011,
    ADDSM = 3'b100,
    SUBSM = 3'b101,
    AND   = 3'b110,
    OR    = 3'b111
  } sel_t;
  typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_SEL, EXEC, OUT} state_t;
  function automatic logic legal_sel(input logic [DATA_W-1:0] b);
    return b[DATA_W-1:SEL_W] == '0;
  endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: host byte stream, ALU operand/result and result handshake signals
interface alu_seq_if #(parameter int CNT_W = 8) ();
  import alu_pkg::*;
  logic clear;
  logic [DATA_W-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] alu_opA;
  logic [DATA_W-1:0] alu_opB;
  logic [SEL_W-1:0] alu_sel;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic err;
  logic busy;
  logic [CNT_W-1:0] txn_cnt;
  modport master (
    output clear, in_data, in_valid, alu_res, out_ready,
    input in_ready, alu_opA, alu_opB, alu_sel, out_data, out_valid, err, busy, txn_cnt
  );
  modport slave (
    input clear, in_data, in_valid, alu_res, out_ready,
    output in_ready, alu_opA, alu_opB, alu_sel, out_data, out_valid, err, busy, txn_cnt
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: loads opA/opB/sel bytes, holds them for the ALU, captures the result
module alu_seq
  import alu_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  alu_seq_if.slave bus
);
  localparam logic [3:0] TMR = 4'(EXEC_CYCLES - 1);
  state_t state;
  logic [3:0] timer;
  logic [CNT_W-1:0] cnt;
  assign bus.in_ready = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_SEL);
  assign bus.busy = (state == EXEC) || (state == OUT);
  assign bus.txn_cnt = cnt;
  // Sequencer FSM: operand loading, settle timer, result capture and output handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD_A;
      timer <= '0;
      cnt <= '0;
      bus.alu_opA <= '0;
      bus.alu_opB <= '0;
      bus.alu_sel <= '0;
      bus.out_data <= '0;
      bus.out_valid <= 1'b0;
      bus.err <= 1'b0;
    end else if (bus.clear) begin
      state <= LOAD_A;
      bus.out_valid <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.err <= 1'b0;
      case (state)
        LOAD_A: if (bus.in_valid) begin
          bus.alu_opA <= bus.in_data;
          state <= LOAD_B;
        end
        LOAD_B: if (bus.in_valid) begin
          bus.alu_opB <= bus.in_data;
          state <= LOAD_SEL;
        end
        LOAD_SEL: if (bus.in_valid) begin
          if (legal_sel(bus.in_data)) begin
            bus.alu_sel <= bus.in_data[SEL_W-1:0];
            timer <= TMR;
            state <= EXEC;
          end else begin
            bus.err <= 1'b1;
            state <= LOAD_A;
          end
        end
        EXEC: if (timer == '0) begin
          bus.out_data <= bus.alu_res;
          bus.out_valid <= 1'b1;
          state <= OUT;
        end else begin
          timer <= timer - 1'b1;
        end
        OUT: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          cnt <= cnt + 1'b1;
          state <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq with a behavioural ALU as its sibling
module tb_alu_seq;
  import alu_pkg::*;
  logic clk;
  logic rst_n;
  logic u;
  logic clear;
  logic in_valid;
  logic out_ready;
  logic [7:0] in_data;
  int n_cmp = 0;
  int n_bad = 0;
  alu_seq_if #(.CNT_W(8)) bus1 ();
  alu_seq_if #(.CNT_W(8)) bus4 ();
  alu_seq #(.EXEC_CYCLES(1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_seq #(.EXEC_CYCLES(4), .CNT_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  function automatic logic [7:0] sm_add(input logic [7:0] a, input logic [7:0] b);
    if (a[7] == b[7]) return {a[7], 7'(a[6:0] + b[6:0])};
    if (a[6:0] >= b[6:0]) return {a[7], 7'(a[6:0] - b[6:0])};
    return {b[7], 7'(b[6:0] - a[6:0])};
  endfunction
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    logic [8:0] t;
    logic [7:0] nb;
    nb = ~b;
    case (sel_t'(s))
      ADD2C: return a + b;
      SUB2C: return a - b;
      ADD1C: begin
        t = {1'b0, a} + {1'b0, b};
        return t[7:0] + {7'd0, t[8]};
      end
      SUB1C: begin
        t = {1'b0, a} + {1'b0, nb};
        return t[7:0] + {7'd0, t[8]};
      end
      ADDSM: return sm_add(a, b);
      SUBSM: return sm_add(a, {~b[7], b[6:0]});
      AND: return a & b;
      default: return a | b;
    endcase
  endfunction
  assign bus1.alu_res = alu(bus1.alu_opA, bus1.alu_opB, bus1.alu_sel);
  assign bus4.alu_res = alu(bus4.alu_opA, bus4.alu_opB, bus4.alu_sel);
  assign bus1.in_data = in_data;
  assign bus4.in_data = in_data;
  assign bus1.in_valid = in_valid & ~u;
  assign bus4.in_valid = in_valid & u;
  assign bus1.out_ready = out_ready & ~u;
  assign bus4.out_ready = out_ready & u;
  assign bus1.clear = clear & ~u;
  assign bus4.clear = clear & u;
  wire o_rdy = u ? bus4.in_ready : bus1.in_ready;
  wire o_valid = u ? bus4.out_valid : bus1.out_valid;
  wire [7:0] o_data = u ? bus4.out_data : bus1.out_data;
  wire [7:0] o_cnt = u ? bus4.txn_cnt : bus1.txn_cnt;
  wire o_err = u ? bus4.err : bus1.err;
  wire o_busy = u ? bus4.busy : bus1.busy;
  wire [7:0] o_opa = u ? bus4.alu_opA : bus1.alu_opA;
  wire [2:0] o_sel = u ? bus4.alu_sel : bus1.alu_sel;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int k = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!o_rdy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) chk("in_ready_timeout", o_rdy, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s,
                     input logic [7:0] exp, input int lat, input int hold);
    int k = 0;
    send(a);
    send(b);
    send(s);
    chk("busy_exec", o_busy, 1);
    chk("rdy_exec", o_rdy, 0);
    while (!o_valid && k < 40) begin
      @(posedge clk);
      #1 k++;
    end
    chk("latency", k, lat);
    chk("out_data", o_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", o_valid, 1);
      chk("hold_data", o_data, exp);
      chk("hold_rdy", o_rdy, 0);
      chk("hold_busy", o_busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("drop_valid", o_valid, 0);
    chk("rdy_after", o_rdy, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int seen;
    int hs;
    u = 1'b0;
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", o_rdy, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_cnt", o_cnt, 0);
    chk("rst_data", o_data, 0);
    chk("rst_opa", o_opa, 0);
    chk("rst_sel", o_sel, 0);
    rst_n = 1'b1;
    txn(8'h05, 8'hFB, 8'h00, 8'h00, 1, 0);
    chk("cnt_t1", o_cnt, 1);
    txn(8'h03, 8'h05, 8'h03, 8'hFD, 1, 0);
    txn(8'hF0, 8'h3C, 8'h06, 8'h30, 1, 0);
    chk("cnt_t2", o_cnt, 3);
    txn(8'h01, 8'h02, 8'h07, 8'h03, 1, 5);
    chk("busy_idle", o_busy, 0);
    chk("cnt_t3", o_cnt, 4);
    send(8'h11);
    send(8'h22);
    send(8'h09);
    chk("err_pulse", o_err, 1);
    chk("err_rdy", o_rdy, 1);
    chk("err_valid", o_valid, 0);
    chk("err_sel_kept", o_sel, 3'h7);
    chk("err_opa", o_opa, 8'h11);
    @(posedge clk);
    #1;
    chk("err_drop", o_err, 0);
    chk("err_no_valid", o_valid, 0);
    txn(8'h0A, 8'h14, 8'h00, 8'h1E, 1, 0);
    chk("cnt_t4", o_cnt, 5);
    u = 1'b1;
    txn(8'h02, 8'h03, 8'h00, 8'h05, 4, 0);
    chk("cnt4_first", o_cnt, 1);
    send(8'h04);
    send(8'h04);
    send(8'h00);
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    chk("clr_rdy", o_rdy, 1);
    chk("clr_busy", o_busy, 0);
    chk("clr_valid", o_valid, 0);
    chk("clr_data", o_data, 8'h05);
    chk("clr_opa", o_opa, 8'h04);
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1 seen |= int'(o_valid);
    end
    chk("clr_no_capture", seen, 0);
    chk("clr_cnt", o_cnt, 1);
    chk("clr_err", o_err, 0);
    u = 1'b0;
    send(8'h01);
    send(8'h01);
    send(8'h00);
    @(posedge clk);
    #1;
    chk("out_before_rst", o_valid, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst2_valid", o_valid, 0);
    chk("rst2_data", o_data, 0);
    chk("rst2_cnt", o_cnt, 0);
    chk("rst2_opa", o_opa, 0);
    chk("rst2_rdy", o_rdy, 1);
    chk("rst2_busy", o_busy, 0);
    in_data = 8'h00;
    in_valid = 1'b1;
    out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 1280; i++) begin
      @(negedge clk);
      hs += int'(o_valid);
      if (i == 5) chk("wrap_cnt_5", o_cnt, 1);
      if (i == 1275) chk("wrap_cnt_255", o_cnt, 255);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("wrap_cnt_0", o_cnt, 0);
    chk("wrap_handshakes", hs, 256);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
